// File: rtl/booth_mult_seq.sv
// Sequential signed multiplier using radix-4 modified Booth recoding, one Booth step per clock.
// Optional MULT_EARLY_EXIT_EN: a zero operand skips the Booth steps and finishes two cycles after start.
module booth_mult_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 ctrl_MULT,
    input  logic [WIDTH-1:0]     data_operandA,
    input  logic [WIDTH-1:0]     data_operandB,
    output logic [2*WIDTH-1:0]   product_full,
    output logic [WIDTH-1:0]     data_result,
    output logic                 data_resultRDY,
    output logic                 busy
);

    localparam int ITER = WIDTH / 2;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITER);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic signed [WIDTH-1:0]   a_q, a_d;
    logic signed [WIDTH+1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]          mq_q, mq_d;
    logic                      qm1_q, qm1_d;
    logic [2*WIDTH-1:0]        prod_q, prod_d;

    logic signed [WIDTH+1:0]   pp;
    logic signed [WIDTH+1:0]   sum;
    logic                      skip_run;

    // Two guard bits keep +/-2A exact even for the most negative multiplicand.
    function automatic logic signed [WIDTH+1:0] booth_pp(
        input logic [2:0]              trip,
        input logic signed [WIDTH-1:0] a
    );
        logic signed [WIDTH+1:0] a1;
        a1 = {{2{a[WIDTH-1]}}, a};
        case (trip)
            3'b001, 3'b010: booth_pp = a1;
            3'b011:         booth_pp = a1 <<< 1;
            3'b100:         booth_pp = -(a1 <<< 1);
            3'b101, 3'b110: booth_pp = -a1;
            default:        booth_pp = '0;
        endcase
    endfunction

    assign pp  = booth_pp({mq_q[1:0], qm1_q}, a_q);
    assign sum = acc_q + pp;

`ifdef MULT_EARLY_EXIT_EN
    assign skip_run = (a_q == '0) || (mq_q == '0);
`else
    assign skip_run = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        qm1_d   = qm1_q;
        prod_d  = prod_q;

        case (state_q)
            RUN: begin
                if (skip_run && (cnt_q == '0)) begin
                    state_d = DONE;
                    prod_d  = '0;
                end else if (cnt_q == LAST) begin
                    state_d = DONE;
                    prod_d  = {acc_q[WIDTH-1:0], mq_q};
                end else begin
                    // Add the recoded partial product, then arithmetic shift {acc, mq, q-1} right by 2.
                    acc_d = sum >>> 2;
                    mq_d  = {sum[1:0], mq_q[WIDTH-1:2]};
                    qm1_d = mq_q[1];
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A start pulse in any state restarts; an aborted op never updates the product.
        if (ctrl_MULT) begin
            state_d = RUN;
            a_d     = data_operandA;
            mq_d    = data_operandB;
            acc_d   = '0;
            qm1_d   = 1'b0;
            cnt_d   = '0;
            prod_d  = prod_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            prod_q  <= prod_d;
        end
    end

    // The final RUN cycle only transfers the product, so busy drops while it happens.
    assign product_full   = prod_q;
    assign data_result    = prod_q[WIDTH-1:0];
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q == RUN) && (cnt_q != LAST);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed-vector bench for booth_mult_seq (WIDTH=32); honours MULT_EARLY_EXIT_EN for the zero-operand case.
module tb_booth_mult_seq;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;
    localparam int LAT   = 17;
    localparam int BUSYN = 16;
`ifdef MULT_EARLY_EXIT_EN
    localparam int ZLAT  = 1;
    localparam int ZBUSY = 1;
`else
    localparam int ZLAT  = 17;
    localparam int ZBUSY = 16;
`endif

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 ctrl_MULT = 1'b0;
    logic [WIDTH-1:0]     data_operandA = '0;
    logic [WIDTH-1:0]     data_operandB = '0;
    logic [2*WIDTH-1:0]   product_full;
    logic [WIDTH-1:0]     data_result;
    logic                 data_resultRDY;
    logic                 busy;

    int vecs = 0;
    int errs = 0;

    booth_mult_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .product_full   (product_full),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    // Called at a negedge; returns at the negedge right after the start edge.
    task automatic drive_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        ctrl_MULT     = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h1234_5678;
    endtask

    // n = number of edges after the start edge until RDY is seen (-1 on timeout).
    task automatic wait_rdy(output int n, output int bcnt);
        n = -1;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy) bcnt++;
            if (data_resultRDY) begin
                n = i;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        vecs++;
        if ({product_full, data_result, data_resultRDY, busy} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got prod=%h res=%h rdy=%b busy=%b, want all 0",
                     product_full, data_result, data_resultRDY, busy);
        end
        reset_n = 1'b1;
        @(negedge clock);
        vecs++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL idle_after_reset: got rdy=%b busy=%b, want 0 0", data_resultRDY, busy);
        end
    endtask

    task automatic test_vector(input string name, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic [2*WIDTH-1:0] exp);
        int n, bc;
        drive_start(a, b);
        wait_rdy(n, bc);
        vecs++;
        if (n !== LAT) begin
            errs++;
            $display("FAIL %s_latency: got %0d, want %0d", name, n, LAT);
        end
        vecs++;
        if (bc !== BUSYN) begin
            errs++;
            $display("FAIL %s_busy_cycles: got %0d, want %0d", name, bc, BUSYN);
        end
        vecs++;
        if (product_full !== exp) begin
            errs++;
            $display("FAIL %s_product: got %h, want %h", name, product_full, exp);
        end
        vecs++;
        if (data_result !== exp[WIDTH-1:0]) begin
            errs++;
            $display("FAIL %s_result: got %h, want %h", name, data_result, exp[WIDTH-1:0]);
        end
        @(negedge clock);
        vecs++;
        if (data_resultRDY !== 1'b0 || product_full !== exp) begin
            errs++;
            $display("FAIL %s_hold: got rdy=%b prod=%h, want rdy=0 prod=%h", name, data_resultRDY, product_full, exp);
        end
    endtask

    task automatic test_arith();
        logic [2*WIDTH-1:0] ovf_bits;
        logic ovf;
        test_vector("pos_small", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
        test_vector("neg_pos", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
        test_vector("min_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        ovf_bits = product_full;
        ovf = !((&ovf_bits[63:31]) || !(|ovf_bits[63:31]));
        vecs++;
        if (ovf !== 1'b1) begin
            errs++;
            $display("FAIL min_min_overflow: got %b, want 1", ovf);
        end
        test_vector("hi_word", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
        test_vector("neg_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        test_vector("max_min", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
        test_vector("max_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
    endtask

    task automatic test_output_hold();
        logic [2*WIDTH-1:0] prev;
        int bad;
        prev = product_full;
        bad = 0;
        drive_start(32'd100, 32'd7);
        for (int i = 0; i < 10; i++) begin
            if (product_full !== prev) bad++;
            @(negedge clock);
        end
        vecs++;
        if (bad !== 0) begin
            errs++;
            $display("FAIL hold_while_busy: got %0d changed cycles, want 0", bad);
        end
        repeat (10) @(negedge clock);
        vecs++;
        if (product_full !== 64'd700) begin
            errs++;
            $display("FAIL hold_result: got %h, want %h", product_full, 64'd700);
        end
    endtask

    task automatic test_restart();
        int n, bc, early;
        early = 0;
        drive_start(32'd2, 32'd3);
        for (int i = 0; i < 8; i++) begin
            if (data_resultRDY) early++;
            @(negedge clock);
        end
        drive_start(32'd4, 32'd4);
        wait_rdy(n, bc);
        vecs++;
        if (early !== 0 || n !== LAT) begin
            errs++;
            $display("FAIL restart_latency: got early=%0d n=%0d, want early=0 n=%0d", early, n, LAT);
        end
        vecs++;
        if (product_full !== 64'd16) begin
            errs++;
            $display("FAIL restart_product: got %h, want %h", product_full, 64'd16);
        end
        @(negedge clock);
    endtask

    task automatic test_held_start();
        int n, bc;
        ctrl_MULT = 1'b1;
        data_operandA = 32'd1;
        data_operandB = 32'd1;
        @(posedge clock);
        @(negedge clock);
        data_operandA = 32'd5;
        data_operandB = 32'd5;
        @(posedge clock);
        @(negedge clock);
        data_operandA = 32'd6;
        data_operandB = 32'd7;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        wait_rdy(n, bc);
        vecs++;
        if (n !== LAT || product_full !== 64'd42) begin
            errs++;
            $display("FAIL held_start: got n=%0d prod=%h, want n=%0d prod=%h", n, product_full, LAT, 64'd42);
        end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        int n, bc;
        drive_start(32'd3, 32'd5);
        wait_rdy(n, bc);
        ctrl_MULT = 1'b1;
        data_operandA = 32'hFFFF_FFFD;
        data_operandB = 32'hFFFF_FFFC;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        vecs++;
        if (n !== LAT || data_resultRDY !== 1'b0 || busy !== 1'b1 || product_full !== 64'd15) begin
            errs++;
            $display("FAIL b2b_done_restart: got n=%0d rdy=%b busy=%b prod=%h, want n=%0d rdy=0 busy=1 prod=%h",
                     n, data_resultRDY, busy, product_full, LAT, 64'd15);
        end
        wait_rdy(n, bc);
        vecs++;
        if (n !== LAT || product_full !== 64'd12) begin
            errs++;
            $display("FAIL b2b_second: got n=%0d prod=%h, want n=%0d prod=%h", n, product_full, LAT, 64'd12);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        int n, bc;
        drive_start(32'd123, 32'd456);
        repeat (5) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        vecs++;
        if ({product_full, data_result, data_resultRDY, busy} !== '0) begin
            errs++;
            $display("FAIL async_reset: got prod=%h res=%h rdy=%b busy=%b, want all 0",
                     product_full, data_result, data_resultRDY, busy);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        drive_start(32'd0, 32'd9);
        wait_rdy(n, bc);
        vecs++;
        if (n !== ZLAT || bc !== ZBUSY) begin
            errs++;
            $display("FAIL zero_latency: got n=%0d busy=%0d, want n=%0d busy=%0d", n, bc, ZLAT, ZBUSY);
        end
        vecs++;
        if (product_full !== '0 || data_result !== '0) begin
            errs++;
            $display("FAIL zero_product: got %h, want 0", product_full);
        end
        @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_arith();
        test_output_hold();
        test_restart();
        test_held_start();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
